// File: rtl/ifu_npc_pkg.sv
// npc_pkg: next-PC op encodings and reset constants shared by the fetch unit.
package npc_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/ifu_npc_calc.sv
// npc_calc: combinational redirect target and taken decision for the
// control instruction currently held in D.
import npc_pkg::*;

module npc_calc (
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic [31:0] rs,
    input  logic [1:0]  op,
    input  logic        zero,
    input  logic        br_ne,
    output logic [31:0] target,
    output logic        taken
);

    logic [31:0] pc4_d;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        unused_opcode;

    assign pc4_d         = pc_d + 32'd4;
    assign br_tgt        = pc4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign j_tgt         = {pc4_d[31:28], instr_d[25:0], 2'b00};
    assign unused_opcode = ^instr_d[31:26];

    // Select target and taken by op; jr target is passed through unmasked.
    always_comb begin
        target = pc4_d;
        taken  = 1'b0;
        case (npc_op_e'(op))
            NPC_BR: begin
                target = br_tgt;
                taken  = zero ^ br_ne;
            end
            NPC_J: begin
                target = j_tgt;
                taken  = 1'b1;
            end
            NPC_JR: begin
                target = rs;
                taken  = 1'b1;
            end
            default: begin
                target = pc4_d;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ifu_npc.sv
// ifu_npc: F-stage PC and IF/ID pipeline register with D-stage redirect,
// single delay slot. Optional macro BRANCH_LIKELY_EN adds likely_i, which
// nullifies the delay slot of an untaken branch-likely.
import npc_pkg::*;

module ifu_npc #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic [31:0] instr_f_i,
    input  logic [1:0]  npc_op_i,
    input  logic        zero_i,
    input  logic        br_ne_i,
    input  logic [31:0] rs_d_i,
`ifdef BRANCH_LIKELY_EN
    input  logic        likely_i,
`endif
    output logic [31:0] pc_f_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc8_d_o,
    output logic        redirect_o
);

    logic [31:0] pc_f_q;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;
    logic [31:0] target;
    logic        taken;
    logic        nullify;

    npc_calc u_calc (
        .pc_d    (pc_d_q),
        .instr_d (instr_d_q),
        .rs      (rs_d_i),
        .op      (npc_op_i),
        .zero    (zero_i),
        .br_ne   (br_ne_i),
        .target  (target),
        .taken   (taken)
    );

    assign redirect_o = taken & ~stall_i;

`ifdef BRANCH_LIKELY_EN
    // Untaken branch-likely squashes the slot; the PC still advances by 4.
    assign nullify = (npc_op_i == NPC_BR) & likely_i & ~taken & ~stall_i;
`else
    assign nullify = 1'b0;
`endif

    // PC and IF/ID update: reset beats stall, stall beats redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= NOP_INSTR;
            pc_d_q    <= PC_RESET;
        end else if (!stall_i) begin
            pc_f_q    <= redirect_o ? target : (pc_f_q + 32'd4);
            instr_d_q <= nullify ? NOP_INSTR : instr_f_i;
            pc_d_q    <= pc_f_q;
        end
    end

    assign pc_f_o    = pc_f_q;
    assign instr_d_o = instr_d_q;
    assign pc_d_o    = pc_d_q;
    assign pc8_d_o   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_ifu_npc.sv
// tb_ifu_npc: directed and randomized steps checked against an
// architectural model of the fetch PC and IF/ID register.
module tb_ifu_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic [31:0] instr_f_i;
    logic [1:0]  npc_op_i;
    logic        zero_i;
    logic        br_ne_i;
    logic [31:0] rs_d_i;
    logic        likely;
    logic [31:0] pc_f_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc8_d_o;
    logic        redirect_o;

    int n_checks = 0;
    int n_err    = 0;

    // architectural model state
    logic [31:0] m_pc_f;
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;

    ifu_npc dut (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall_i),
        .instr_f_i  (instr_f_i),
        .npc_op_i   (npc_op_i),
        .zero_i     (zero_i),
        .br_ne_i    (br_ne_i),
        .rs_d_i     (rs_d_i),
`ifdef BRANCH_LIKELY_EN
        .likely_i   (likely),
`endif
        .pc_f_o     (pc_f_o),
        .instr_d_o  (instr_d_o),
        .pc_d_o     (pc_d_o),
        .pc8_d_o    (pc8_d_o),
        .redirect_o (redirect_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic m_taken(input logic [1:0] op, input logic z, input logic ne);
        if (op == 2'd0) return 1'b0;
        if (op == 2'd1) return z != ne;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_target(input logic [1:0] op, input logic [31:0] pcd,
                                             input logic [31:0] ins, input logic [31:0] rs);
        int signed   off;
        logic [31:0] next_seq;
        next_seq = pcd + 32'd4;
        off      = int'($signed(ins[15:0])) * 4;
        case (op)
            2'd1:    return next_seq + 32'(off);
            2'd2:    return (next_seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            2'd3:    return rs;
            default: return next_seq;
        endcase
    endfunction

    // One cycle: apply inputs, check combinational outputs, clock, check state.
    task automatic step(input logic rst, input logic stl, input logic [1:0] op,
                        input logic z, input logic ne, input logic [31:0] ins_f,
                        input logic [31:0] rs, input logic lk);
        logic        tk;
        logic        redir;
        logic [31:0] n_pc_f, n_instr_d, n_pc_d;
        reset = rst; stall_i = stl; npc_op_i = op; zero_i = z; br_ne_i = ne;
        instr_f_i = ins_f; rs_d_i = rs; likely = lk;
        #1;
        tk    = m_taken(op, z, ne);
        redir = tk && !stl;
        chk("redirect", {31'd0, redirect_o}, {31'd0, redir});
        chk("pc8_d", pc8_d_o, m_pc_d + 32'd8);
        if (rst) begin
            n_pc_f = 32'h0000_3000; n_instr_d = 32'h0; n_pc_d = 32'h0000_3000;
        end else if (stl) begin
            n_pc_f = m_pc_f; n_instr_d = m_instr_d; n_pc_d = m_pc_d;
        end else begin
            n_pc_f    = redir ? m_target(op, m_pc_d, m_instr_d, rs) : m_pc_f + 32'd4;
            n_instr_d = ins_f;
`ifdef BRANCH_LIKELY_EN
            if (op == 2'd1 && lk && !tk) n_instr_d = 32'h0;
`endif
            n_pc_d    = m_pc_f;
        end
        @(posedge clk);
        #1;
        m_pc_f = n_pc_f; m_instr_d = n_instr_d; m_pc_d = n_pc_d;
        chk("pc_f", pc_f_o, m_pc_f);
        chk("instr_d", instr_d_o, m_instr_d);
        chk("pc_d", pc_d_o, m_pc_d);
    endtask

    initial begin
        m_pc_f = 32'hx; m_instr_d = 32'hx; m_pc_d = 32'hx;
        // reset while stalled: reset must win
        step(1, 1, 2'd0, 0, 0, 32'h1234_5678, 0, 0);
        step(1, 0, 2'd0, 0, 0, 32'h1234_5678, 0, 0);
        chk("rst_pc_f", pc_f_o, 32'h0000_3000);
        chk("rst_instr_d", instr_d_o, 32'h0);
        // sequential fetch
        step(0, 0, 2'd0, 0, 0, 32'h2401_0001, 0, 0);
        chk("seq_3004", pc_f_o, 32'h0000_3004);
        step(0, 0, 2'd0, 0, 0, 32'h2402_0002, 0, 0);
        step(0, 0, 2'd0, 0, 0, 32'h1000_0003, 0, 0);
        chk("seq_300c", pc_f_o, 32'h0000_300C);
        // beq imm=3 at pc_d=0x3008, taken
        step(0, 0, 2'd1, 1, 0, 32'h1000_FFFE, 0, 0);
        chk("beq_tgt", pc_f_o, 32'h0000_3018);
        chk("beq_slot", instr_d_o, 32'h1000_FFFE);
        // beq imm=0xFFFE at pc_d=0x300C: backwards
        step(0, 0, 2'd1, 1, 0, 32'h0C00_0C10, 0, 0);
        chk("beq_back", pc_f_o, 32'h0000_3008);
        // jal 0x0C000C10
        step(0, 0, 2'd2, 0, 0, 32'h1400_0005, 0, 0);
        chk("jal_tgt", pc_f_o, 32'h0000_3040);
        // bne with zero=1: not taken
        step(0, 0, 2'd1, 1, 1, 32'h03E0_0008, 0, 0);
        chk("bne_nt", pc_f_o, 32'h0000_3044);
        // jr
        step(0, 0, 2'd3, 0, 0, 32'h1000_0004, 32'h0000_3100, 0);
        chk("jr_tgt", pc_f_o, 32'h0000_3100);
        // beq taken held by stall for two cycles, fires when stall drops
        step(0, 1, 2'd1, 1, 0, 32'hDEAD_BEEF, 0, 0);
        step(0, 1, 2'd1, 1, 0, 32'hDEAD_BEEF, 0, 0);
        chk("stall_pc_f", pc_f_o, 32'h0000_3100);
        step(0, 0, 2'd1, 1, 0, 32'hCAFE_0001, 0, 0);
        chk("stall_release", pc_f_o, 32'h0000_3058);
`ifdef BRANCH_LIKELY_EN
        // beql not taken: slot nullified
        step(0, 0, 2'd1, 0, 0, 32'h2403_0003, 0, 1);
        chk("likely_null", instr_d_o, 32'h0);
`endif
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 $urandom, $urandom, 1'($urandom));
        end
        // final reset during stall
        step(1, 1, 2'd3, 0, 0, 32'hFFFF_FFFF, 32'h1, 0);
        chk("final_rst", pc_f_o, 32'h0000_3000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_npc.md
Name: ifu_npc

Overview:
- Fetch-side consumer of the D-stage equality compare result (`zero_i`).
- Owns the F-stage PC register and the IF/ID pipeline register.
- Resolves branch, jump and jr redirects in D. MIPS single delay slot semantics.
- Sits between the instruction memory (external) and the D-stage decoder/register-file read.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on reset (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard-unit stall; freezes PC and IF/ID.
- instr_f_i  input  32  instruction word read from IM at pc_f_o (combinational IM).
- npc_op_i  input  2  from D decoder: 00 SEQ, 01 BR, 10 J/JAL, 11 JR.
- zero_i  input  1  compare result, 1 when D-stage operands are equal.
- br_ne_i  input  1  1 for bne (taken when zero_i=0), 0 for beq.
- rs_d_i  input  32  forwarded rs value in D, used as the jr/jalr target.
- pc_f_o  output  32  current fetch PC, drives IM address.
- instr_d_o  output  32  IF/ID instruction.
- pc_d_o  output  32  IF/ID PC.
- pc8_d_o  output  32  pc_d_o+8, link value for jal/jalr.
- redirect_o  output  1  a redirect is applied this cycle.

Behaviour:
- Reset (sync, overrides stall): pc_f_o=PC_RESET, instr_d_o=NOP_INSTR, pc_d_o=PC_RESET. redirect_o is combinational and reads 0 because of the NOP decode.
- Combinational values:
  - pc4_d = pc_d_o+4.
  - br_tgt = pc4_d + {{14{instr_d_o[15]}}, instr_d_o[15:0], 2'b00}.
  - j_tgt = {pc4_d[31:28], instr_d_o[25:0], 2'b00}.
  - jr_tgt = rs_d_i, used unmodified; no alignment masking.
  - All adds are modulo 2^32; wrap-around is silent.
- taken is:
  - 1 when op=BR and (zero_i XOR br_ne_i)=1;
  - 1 when op=J or op=JR;
  - 0 when op=SEQ.
- redirect_o = taken & ~stall_i.
- Next-state rule, in priority order:
  - reset: load reset values.
  - stall_i=1: hold pc_f, instr_d and pc_d. No redirect, even when a branch is in D.
  - redirect_o=1: pc_f <= target for the op. IF/ID loads {instr_f_i, pc_f_o}; this is the delay slot and it always executes.
  - otherwise: pc_f <= pc_f+4. IF/ID loads {instr_f_i, pc_f_o}.
- Latency:
  - branch in D at cycle t, not stalled: target appears on pc_f_o at t+1.
  - delay slot appears in D at t+1; target instruction appears in D at t+2.
- Branch in D whose operands are stalled: it remains in D, and the redirect is evaluated on the first unstalled cycle.
- Back-to-back control instructions (branch in a delay slot) are architecturally undefined. Required behaviour: the second redirect simply applies on its own cycle.

Optional Feature:
- Macro BRANCH_LIKELY_EN.
- Defined:
  - Adds input likely_i (1 bit, from D decoder; beql/bnel).
  - When op=BR, likely_i=1, condition false and stall_i=0: the delay slot is nullified. IF/ID loads {NOP_INSTR, pc_f_o}, and pc_f advances by +4 as normal.
  - When taken, behaviour is unchanged.
- Not defined: port absent; the delay slot always executes.

Decomposition:
- Package npc_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR 2-bit encodings;
  - PC_RESET_DEF and NOP_INSTR_DEF constants.
- One combinational sub-module, npc_calc: takes pc_d, instr_d, rs, op, zero, br_ne and returns target and taken.
- ifu_npc holds only the registers and the stall/priority logic.

Test Plan:
- Reset, then release with op=SEQ → pc_f_o=0x3000, instr_d_o=0 during reset; 0x3004, 0x3008, 0x300C on the following edges; redirect_o=0.
- beq in D with pc_d=0x3008, imm=0x0003, zero_i=1, br_ne_i=0 → redirect_o=1; next pc_f_o=0x3018; next instr_d_o is the word fetched at 0x300C.
- bne with zero_i=1 → not taken, pc_f_o+4. beq with imm=0xFFFE, pc_d=0x300C, zero_i=1 → pc_f_o=0x3008.
- jal 0x0C000C10 at pc_d=0x3000 → pc_f_o=0x00003040, pc8_d_o=0x3008. jr with rs_d_i=0x0000_3100 → pc_f_o=0x3100.
- beq taken with stall_i=1 for 2 cycles → pc_f_o, instr_d_o and pc_d_o frozen, redirect_o=0; the redirect fires on the cycle stall drops.
- reset asserted while stall_i=1 → next edge pc_f_o=0x3000, instr_d_o=0. With BRANCH_LIKELY_EN: beql not taken → instr_d_o=0 next cycle.
